// File: rtl/bus_cmd_pkg.sv
// bus_cmd_pkg: shared command payload, queue FSM states and transfer mode encodings.
package bus_cmd_pkg;
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        mode;
   } cmd_t;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} mcq_state_e;
   localparam logic MODE_WRITE = 1'b1;
   localparam logic MODE_READ  = 1'b0;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: DEPTH-entry command FIFO (DEPTH power of two).
// Ports: clk, rst (async high); i_push/i_data write side, i_pop/o_data read side
// (o_data is the current head); o_full, o_empty, o_count occupancy.
module cmd_fifo
   import bus_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  cmd_t                   i_data,
   input  logic                   i_pop,
   output cmd_t                   o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   cmd_t          r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_data  = r_mem[r_rptr];
   assign o_count = r_count;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
endmodule

// File: rtl/master_cmd_queue.sv
// master_cmd_queue: queues read/write commands and feeds them one at a time to a bus master.
// Ports: cmd_* command stream in (cmd_ready = !full); rsp_* in-order response stream out;
// U_* / state_show master user port; busy = FSM not idle; fifo_count = occupancy.
// Optional MCQ_TIMEOUT_EN: watchdog of TIMEOUT_CYCLES forces an error response (rsp_err).
module master_cmd_queue
   import bus_cmd_pkg::*;
#(
   parameter int         DEPTH          = 4,
   parameter logic [2:0] IDLE_STATE     = 3'd0,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [15:0]            cmd_addr,
   input  logic [7:0]             cmd_wdata,
   input  logic                   cmd_mode,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [7:0]             rsp_rdata,
   output logic                   rsp_err,
   output logic                   U_start,
   output logic [15:0]            U_addr,
   output logic [7:0]             U_wdata,
   output logic                   U_mode,
   input  logic [7:0]             U_rdata,
   input  logic [2:0]             state_show,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);
   mcq_state_e r_state;
   cmd_t       w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_pop;
   assign w_pop     = (r_state == IDLE) && !w_empty;
   assign cmd_ready = !w_full;
   assign busy      = r_state != IDLE;
   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .i_push (cmd_valid),
      .i_data ('{addr: cmd_addr, wdata: cmd_wdata, mode: cmd_mode}),
      .i_pop  (w_pop),
      .o_data (w_head),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_count(fifo_count)
   );
`ifdef MCQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] r_tmr;
   logic          r_err;
   assign rsp_err = r_err;
`else
   assign rsp_err = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         U_start   <= 1'b0;
         U_addr    <= '0;
         U_wdata   <= '0;
         U_mode    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef MCQ_TIMEOUT_EN
         r_tmr     <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: if (!w_empty) begin
               U_addr  <= w_head.addr;
               U_wdata <= w_head.wdata;
               U_mode  <= w_head.mode;
               U_start <= 1'b1;
               r_state <= LAUNCH;
`ifdef MCQ_TIMEOUT_EN
               r_tmr   <= '0;
`endif
            end
            LAUNCH: if (state_show != IDLE_STATE) begin
               U_start <= 1'b0;
               r_state <= WAIT_DONE;
            end
            WAIT_DONE: if (state_show == IDLE_STATE) begin
               rsp_rdata <= (U_mode == MODE_READ) ? U_rdata : 8'h00;
               rsp_valid <= 1'b1;
               r_state   <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               r_state   <= IDLE;
`ifdef MCQ_TIMEOUT_EN
               r_err     <= 1'b0;
`endif
            end
            default: r_state <= IDLE;
         endcase
`ifdef MCQ_TIMEOUT_EN
         // assigned after the case so the watchdog overrides any normal transition
         if (r_state == LAUNCH || r_state == WAIT_DONE) begin
            r_tmr <= r_tmr + 1'b1;
            if (r_tmr == TW'(TIMEOUT_CYCLES - 1)) begin
               U_start   <= 1'b0;
               rsp_rdata <= 8'h00;
               r_err     <= 1'b1;
               rsp_valid <= 1'b1;
               r_state   <= RESP;
            end
         end
`endif
      end
   end
endmodule

// File: doc/master_cmd_queue.md
Name: master_cmd_queue

Overview:
- Command-buffering front end placed directly upstream of one master's user port (U_start/U_addr/U_wdata/U_mode in, U_rdata/state_show back) in the two-master bus top.
- Accepts read/write commands over a valid/ready stream and queues them in a FIFO.
- Launches commands one at a time into the master and tracks master state to detect completion.
- Returns one response per command, in order, over a valid/ready stream.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- IDLE_STATE, 3'd0, state_show value meaning master idle.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with MCQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_addr  in  16  command address
- cmd_wdata  in  8  write data
- cmd_mode  in  1  1 = write, 0 = read; passed to U_mode unchanged
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_rdata  out  8  read data; 8'h00 for writes
- rsp_err  out  1  timeout flag; constant 0 without MCQ_TIMEOUT_EN
- U_start  out  1  to master start
- U_addr  out  16  to master
- U_wdata  out  8  to master
- U_mode  out  1  to master
- U_rdata  in  8  from master
- state_show  in  3  master FSM state
- busy  out  1  FSM not in IDLE
- fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, immediate):
  - Outputs: U_start=0, U_addr=0, U_wdata=0, U_mode=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, fifo_count=0, cmd_ready=1.
  - FIFO flushed; FSM to IDLE. Reset mid-transaction drops the in-flight command and any pending response.
- Push: on cmd_valid && cmd_ready at a rising edge, {addr, wdata, mode} is written and count increments.
- Full condition: cmd_ready depends only on full, not on a same-cycle pop. A push offered while full is not accepted and has no effect.
- Pointers: wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE: if FIFO not empty, pop the head, register U_addr/U_wdata/U_mode, set U_start=1, go LAUNCH.
  - LAUNCH: hold U_start=1 until state_show != IDLE_STATE. On that edge drop U_start to 0 and go WAIT_DONE.
  - WAIT_DONE: when state_show == IDLE_STATE, capture rsp_rdata (U_rdata if U_mode=0, else 8'h00), set rsp_valid=1, go RESP.
  - RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready. On the handshake edge clear rsp_valid and go IDLE.
- Only one command is outstanding at a time. No new launch happens while a response is unaccepted (rsp_ready backpressure stalls the master side).
- Latency: command accepted at edge N into an empty FIFO with FSM in IDLE → U_start high after edge N+1.
- Response to next launch: rsp handshake at edge M → next U_start high after edge M+1 if FIFO non-empty.
- U_addr/U_wdata/U_mode hold their value from launch until the next pop.

Optional Feature:
- Macro MCQ_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to LAUNCH and increments each cycle in LAUNCH or WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: force U_start=0, rsp_rdata=8'h00, rsp_err=1, rsp_valid=1, go RESP.
  - rsp_err clears on the handshake.
- When undefined: no counter, rsp_err tied 0, and the FSM waits indefinitely.

Decomposition:
- Package bus_cmd_pkg holds:
  - cmd_t struct {logic [15:0] addr; logic [7:0] wdata; logic mode;}
  - mcq_state_e enum {IDLE, LAUNCH, WAIT_DONE, RESP}
  - MODE_WRITE=1'b1 / MODE_READ=1'b0 constants.
- One sub-module: cmd_fifo (parameter DEPTH, cmd_t payload, push/pop/full/empty/count).

Test Plan:
- Single read: push addr 16'h1234, mode 0; master model shows state 3'd1 for 3 cycles, then 0 with U_rdata=8'hA5 → U_addr=16'h1234, U_start high until state 1 seen; rsp_valid with rsp_rdata=8'hA5, rsp_err=0.
- Write then read ordering: push write (16'h0010, 8'h3C) then read 16'h0010 → responses in order: first 8'h00, second model data; U_mode 1 then 0.
- Full: master held in LAUNCH (never leaves idle, macro off), push 5 commands → first is popped, next 4 fill FIFO; fifo_count=4; cmd_ready=0; 6th push ignored; count stays 4.
- Backpressure: rsp_ready=0 for 10 cycles with 2 queued commands → rsp_valid and rsp_rdata stable; U_start stays 0; launch resumes one edge after handshake.
- Reset mid WAIT_DONE with 2 queued → all outputs at reset values immediately; fifo_count=0; post-reset push starts cleanly.
- Timeout (MCQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): master never leaves idle → rsp_valid=1, rsp_err=1, rsp_rdata=8'h00 exactly 16 cycles after LAUNCH entry; U_start low.
